player_mover: RTL

Converts the five raw active-low joystick lines from GPIO into a debounced, auto-repeating player position on a 40×30 cell grid (16-px cells on 640×480), plus a fire pulse. It sits between the GPIO joystick pins and the VGA renderer, which consumes `o_x`/`o_y`/`o_fire`. LED outputs mirror the debounced button levels.

---
 rtl/player_pkg.sv | 24 ++
 rtl/axis_repeat.sv | 111 +++++++++++
 rtl/player_mover.sv | 111 +++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// player_pkg: shared types and constants for the joystick player mover.
//   axis_state_t  : per-axis auto-repeat FSM state
//   GRID_W/GRID_H : playfield size in cells; CELL_PX: cell size in pixels
//   BTN_*         : bit positions of each button in the debounced vector
package player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } axis_state_t;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int CELL_PX = 16;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;
  localparam int NUM_BTN   = 5;

endpackage

// File: rtl/axis_repeat.sv
// axis_repeat: one movement axis. Turns a pair of debounced direction levels
// into single steps plus timed auto-repeat, and keeps the saturating position.
//   CLOCK_50, RST_N : clock, async active-low reset
//   inc, dec        : debounced levels moving toward MAX / toward 0
//   pos             : registered position, 0..MAX
//   moved           : registered one-cycle pulse when pos changed
//
// state | meaning
// IDLE  | no direction held, timer cleared
// HOLD  | first step taken, waiting REPEAT_DELAY for the first repeat
// RPT   | repeating one step every REPEAT_RATE cycles
module axis_repeat
  import player_pkg::*;
#(
  parameter int MAX          = 39,
  parameter int INIT         = 20,
  parameter int W            = 6,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic         CLOCK_50,
  input  logic         RST_N,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] pos,
  output logic         moved
);

  localparam logic [24:0]  DELAY_TC = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0]  RATE_TC  = 25'(REPEAT_RATE - 1);
  localparam logic [W-1:0] POS_MAX  = W'(MAX);
  localparam logic [W-1:0] POS_INIT = W'(INIT);

  axis_state_t  state, state_nxt;
  logic [24:0]  timer, timer_nxt;
  logic         dir_neg, dir_neg_nxt;
  logic [W-1:0] pos_nxt;
  logic         step;
  logic         want_pos, want_neg;

  // Both or neither pressed cancels to no motion.
  assign want_pos = inc & ~dec;
  assign want_neg = dec & ~inc;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    dir_neg_nxt = dir_neg;
    step        = 1'b0;
    if (!(want_pos || want_neg)) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          step        = 1'b1;
          timer_nxt   = '0;
          state_nxt   = HOLD;
          dir_neg_nxt = want_neg;
        end
        HOLD, RPT: begin
          if (want_neg != dir_neg) begin
            // Instant reversal behaves like a fresh press.
            step        = 1'b1;
            timer_nxt   = '0;
            state_nxt   = HOLD;
            dir_neg_nxt = want_neg;
          end else if (timer == ((state == HOLD) ? DELAY_TC : RATE_TC)) begin
            step      = 1'b1;
            timer_nxt = '0;
            state_nxt = RPT;
          end else begin
            timer_nxt = timer + 25'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    pos_nxt = pos;
    if (step) begin
      if (dir_neg_nxt) begin
        if (pos != '0) pos_nxt = pos - 1'b1;
      end else begin
        if (pos != POS_MAX) pos_nxt = pos + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      timer   <= '0;
      dir_neg <= 1'b0;
      pos     <= POS_INIT;
      moved   <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      dir_neg <= dir_neg_nxt;
      pos     <= pos_nxt;
      moved   <= (pos_nxt != pos);
    end
  end

endmodule

// File: rtl/player_mover.sv
// player_mover: raw active-low joystick lines -> debounced, auto-repeating
// player cell position plus fire pulse.
//   CLOCK_50, RST_N                 : 50 MHz clock, async active-low reset
//   i_up/i_down/i_left/i_right/i_fire : raw joystick lines, 0 = pressed
//   o_x, o_y   : player column / row (row 0 at top)
//   o_moved    : pulse on any cycle o_x or o_y changes
//   o_fire     : pulse per debounced fire press
//   o_led      : debounced pressed levels {fire, right, left, down, up}
module player_mover
  import player_pkg::*;
#(
  parameter int DEB_CYCLES   = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int X_MAX        = 39,
  parameter int Y_MAX        = 29,
  parameter int X_INIT       = 20,
  parameter int Y_INIT       = 15
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  output logic [5:0] o_x,
  output logic [4:0] o_y,
  output logic       o_moved,
  output logic       o_fire,
  output logic [4:0] o_led
);

  localparam int              DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]   DEB_TC = DW'(DEB_CYCLES - 1);

  logic [NUM_BTN-1:0] pressed_raw;
  logic [NUM_BTN-1:0] sync1, sync2;
  logic [NUM_BTN-1:0] deb;
  logic               fire_prev;
  logic               moved_x, moved_y;

  // Inverting ahead of the synchronizer is equivalent to inverting after it
  // and lets the cleared flops mean "not pressed".
  assign pressed_raw = ~{i_fire, i_right, i_left, i_down, i_up};

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pressed_raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          level;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[g] == level) begin
        cnt <= '0;
      end else if (cnt == DEB_TC) begin
        cnt   <= '0;
        level <= sync2[g];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[g] = level;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      fire_prev <= 1'b0;
      o_fire    <= 1'b0;
    end else begin
      fire_prev <= deb[BTN_FIRE];
      o_fire    <= deb[BTN_FIRE] & ~fire_prev;
    end
  end

  assign o_led = deb;

  axis_repeat #(
    .MAX(X_MAX), .INIT(X_INIT), .W(6),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_axis_x (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N),
    .inc(deb[BTN_RIGHT]), .dec(deb[BTN_LEFT]),
    .pos(o_x), .moved(moved_x)
  );

  axis_repeat #(
    .MAX(Y_MAX), .INIT(Y_INIT), .W(5),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_axis_y (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N),
    .inc(deb[BTN_DOWN]), .dec(deb[BTN_UP]),
    .pos(o_y), .moved(moved_y)
  );

  // OR of two flops: no input-to-output combinational path.
  assign o_moved = moved_x | moved_y;

endmodule
